mem_lsu_ctrl: RTL and testbench

//  Load/store sequencer between the core's data-access request and the byte-addressed

---
 rtl/mem_lsu_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mem_lsu_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_ctrl.sv
// rtl/mem_lsu_ctrl.sv - load/store sequencer for the unified memory data port
module mem_lsu_ctrl #(
    parameter int MEM_SIZE = 4096,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [31:0]      mem_r_addr,
    input  logic [WIDTH-1:0] mem_r_data,
    output logic             mem_w_enable,
    output logic [31:0]      mem_w_addr,
    output logic [WIDTH-1:0] mem_w_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW,
        S_WRITE,
        S_WAIT_W,
        S_ERR,
        S_RESP
    } state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] addr_a_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic        w_en_q;
    logic [31:0] w_addr_q;
    logic [31:0] w_data_q;

    logic [31:0] addr_a_in;
    logic        range_err;
    logic        req_err;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Decode of the incoming request: aligned word address and error conditions
    always_comb begin
        addr_a_in = {req_addr[31:2], 2'b00};
        range_err = ({1'b0, addr_a_in} + 33'd3) >= 33'(MEM_SIZE);
        req_err   = (req_size == 2'd3)
                  | ((req_size == 2'd1) & req_addr[0])
                  | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00))
                  | range_err;
    end

    // Lane extraction and sign/zero extension of the word read back for a load
    always_comb begin
        load_val = mem_r_data;
        case (size_q)
            2'd0: begin
                logic [7:0] b;
                case (lane_q)
                    2'd0:    b = mem_r_data[7:0];
                    2'd1:    b = mem_r_data[15:8];
                    2'd2:    b = mem_r_data[23:16];
                    default: b = mem_r_data[31:24];
                endcase
                load_val = {{24{b[7] & ~uns_q}}, b};
            end
            2'd1: begin
                logic [15:0] h;
                h = lane_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
                load_val = {{16{h[15] & ~uns_q}}, h};
            end
            default: load_val = mem_r_data;
        endcase
    end

    // Merge of sub-word store data into the word read back for read-modify-write
    always_comb begin
        merged = mem_r_data;
        if (size_q == 2'd0) begin
            case (lane_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Sequencer: captures a request in IDLE and walks it through load, RMW, write or error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            lane_q       <= 2'd0;
            addr_a_q     <= 32'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            w_en_q       <= 1'b0;
            w_addr_q     <= 32'd0;
            w_data_q     <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            w_en_q       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        size_q   <= req_size;
                        uns_q    <= req_unsigned;
                        lane_q   <= req_addr[1:0];
                        addr_a_q <= addr_a_in;
                        wdata_q  <= req_wdata;
                        if (req_err) begin
                            state <= S_ERR;
                        end else if (!req_we) begin
                            state <= S_LOAD;
                        end else if (req_size == 2'd2) begin
                            w_en_q   <= 1'b1;
                            w_addr_q <= addr_a_in;
                            w_data_q <= req_wdata;
                            state    <= S_WRITE;
                        end else begin
                            state <= S_RMW;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_q      <= load_val;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    state        <= S_RESP;
                end
                S_RMW: begin
                    w_en_q   <= 1'b1;
                    w_addr_q <= addr_a_q;
                    w_data_q <= merged;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    state <= S_WAIT_W;
                end
                S_WAIT_W: begin
                    rdata_q      <= 32'd0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    state        <= S_RESP;
                end
                S_ERR: begin
                    rdata_q      <= 32'd0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    rdata_q    <= 32'd0;
                    resp_err_q <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted so no write can leak out mid-reset
    always_comb begin
        req_ready    = (state == S_IDLE) & rst_n;
        resp_valid   = resp_valid_q & rst_n;
        resp_err     = resp_err_q & rst_n;
        resp_rdata   = rdata_q & {WIDTH{rst_n}};
        mem_r_addr   = addr_a_q & {32{rst_n}};
        mem_w_enable = w_en_q & rst_n;
        mem_w_addr   = w_addr_q & {32{rst_n}};
        mem_w_data   = w_data_q & {WIDTH{rst_n}};
    end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// tb/tb_mem_lsu_ctrl.sv - directed self-checking bench for mem_lsu_ctrl
module tb_mem_lsu_ctrl;

    localparam int MEM_SIZE = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_r_data;
    logic        mem_w_enable;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;

    int vectors = 0;
    int fails = 0;

    mem_lsu_ctrl #(.MEM_SIZE(MEM_SIZE), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .mem_w_enable(mem_w_enable), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write registered at posedge and applied at negedge
    logic [31:0] mem [0:1023];
    logic        wp = 1'b0;
    logic [31:0] wa = 32'd0;
    logic [31:0] wd = 32'd0;
    assign mem_r_data = mem[mem_r_addr[11:2]];
    always @(posedge clk) begin
        wp <= mem_w_enable;
        wa <= mem_w_addr;
        wd <= mem_w_data;
    end
    always @(negedge clk) begin
        if (wp) mem[wa[11:2]] <= wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdat,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int pulses);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdat;
        @(posedge clk);
        lat = -1; pulses = 0; rd = 32'hxxxxxxxx; er = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (mem_w_enable) pulses++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    int          lat;
    int          pulses;
    logic [31:0] rd;
    logic        er;
    int          accepts;
    int          resps;
    int          ready_low;
    logic        ready_seen;
    logic        pend;
    logic [31:0] data5 [0:2];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        data5[0] = 32'h000000A1; data5[1] = 32'h000000A2; data5[2] = 32'h000000A3;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_wen", {31'd0, mem_w_enable}, 32'd0);
        check("rst_raddr", mem_r_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, req_ready}, 32'd1);

        // 1: word store then load
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, lat, rd, er, pulses);
        check("sw_lat", lat, 32'd3);
        check("sw_err", {31'd0, er}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        check("sw_pulses", pulses, 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, lat, rd, er, pulses);
        check("lw_lat", lat, 32'd2);
        check("lw_rdata", rd, 32'h11223344);
        check("lw_err", {31'd0, er}, 32'd0);

        // 2: byte store via read-modify-write
        do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB, lat, rd, er, pulses);
        check("sb_lat", lat, 32'd4);
        check("sb_pulses", pulses, 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, lat, rd, er, pulses);
        check("sb_readback", rd, 32'h1122AB44);

        // half store to upper lane
        do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, lat, rd, er, pulses);
        check("sh_lat", lat, 32'd4);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, lat, rd, er, pulses);
        check("sh_readback", rd, 32'hBEEFAB44);

        // 3: load extension
        do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h00008080, lat, rd, er, pulses);
        do_req(1'b0, 2'd0, 1'b0, 32'h200, 32'd0, lat, rd, er, pulses);
        check("lb", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h200, 32'd0, lat, rd, er, pulses);
        check("lbu", rd, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b0, 32'h200, 32'd0, lat, rd, er, pulses);
        check("lh", rd, 32'hFFFF8080);
        do_req(1'b0, 2'd1, 1'b1, 32'h202, 32'd0, lat, rd, er, pulses);
        check("lhu_hi", rd, 32'h00000000);
        do_req(1'b0, 2'd0, 1'b0, 32'h201, 32'd0, lat, rd, er, pulses);
        check("lb_lane1", rd, 32'hFFFFFF80);

        // 4: error cases
        do_req(1'b1, 2'd1, 1'b0, 32'h103, 32'h00001234, lat, rd, er, pulses);
        check("sh_mis_err", {31'd0, er}, 32'd1);
        check("sh_mis_lat", lat, 32'd2);
        check("sh_mis_pulses", pulses, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'd0, lat, rd, er, pulses);
        check("lw_mis_err", {31'd0, er}, 32'd1);
        check("lw_mis_rdata", rd, 32'd0);
        do_req(1'b1, 2'd2, 1'b0, MEM_SIZE - 2, 32'hCAFEF00D, lat, rd, er, pulses);
        check("sw_top_err", {31'd0, er}, 32'd1);
        do_req(1'b1, 2'd2, 1'b0, MEM_SIZE, 32'hCAFEF00D, lat, rd, er, pulses);
        check("sw_range_err", {31'd0, er}, 32'd1);
        check("sw_range_pulses", pulses, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, MEM_SIZE - 4, 32'd0, lat, rd, er, pulses);
        check("lw_last_ok", {31'd0, er}, 32'd0);
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, lat, rd, er, pulses);
        check("size3_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, lat, rd, er, pulses);
        check("err_no_write", rd, 32'hBEEFAB44);

        // 5: back-to-back stores with req_valid held high
        @(negedge clk);
        accepts = 0; resps = 0; ready_low = 0; pend = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h400; req_wdata = data5[0];
        for (int c = 0; c < 30; c++) begin
            if (pend) begin
                accepts++;
                pend = 1'b0;
                if (accepts == 3) req_valid = 1'b0;
                else req_wdata = data5[accepts];
            end
            if (resp_valid) resps++;
            if (req_valid && !req_ready) ready_low++;
            ready_seen = req_ready & req_valid;
            @(posedge clk);
            pend = ready_seen;
            @(negedge clk);
        end
        check("b2b_accepts", accepts, 32'd3);
        check("b2b_resps", resps, 32'd3);
        check("b2b_ready_low", ready_low, 32'd6);
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'd0, lat, rd, er, pulses);
        check("b2b_last_data", rd, 32'h000000A3);

        // 6: reset during WRITE suppresses the write
        do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678, lat, rd, er, pulses);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr = 32'h300; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rw_wen_write", {31'd0, mem_w_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_wen_gated", {31'd0, mem_w_enable}, 32'd0);
        @(negedge clk);
        check("rw_ready", {31'd0, req_ready}, 32'd0);
        check("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rw_resp_err", {31'd0, resp_err}, 32'd0);
        check("rw_rdata", resp_rdata, 32'd0);
        check("rw_raddr", mem_r_addr, 32'd0);
        check("rw_waddr", mem_w_addr, 32'd0);
        check("rw_wdata", mem_w_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rw_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        check("rw_mem_unchanged", mem[32'h300 >> 2], 32'h12345678);
        do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'd0, lat, rd, er, pulses);
        check("rw_load", rd, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
